uart_tx_scheduler: RTL and testbench

//  Shares the single UART transmitter between N_REQ byte-stream requesters (game status, score report, echo, ...).

---
 rtl/uart_tx_scheduler.sv | 128 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin, message-atomic arbiter sharing one UART transmitter between N_REQ byte streams.
// A grant lasts until the owner's 'last' byte has been serialized, or MAX_MSG bytes, or a stall timeout.
module uart_tx_scheduler #(
   parameter int N_REQ       = 4,
   parameter int MAX_MSG     = 32,
   parameter int STALL_LIMIT = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_byte,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ack,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic                 forced_rel,
   input  logic                 tx_ready,
   output logic                 tx_send,
   output logic [7:0]           tx_byte
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(MAX_MSG + 1);
   localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

   typedef enum logic [1:0] {ARB, ISSUE, WAIT_LO, WAIT_HI} state_t;

   state_t                  state;
   logic [IW-1:0]           rr_ptr;
   logic [IW-1:0]           owner;
   logic [IW-1:0]           pick_idx;
   logic [IW-1:0]           next_ptr;
   logic                    pick_found;
   logic [CW-1:0]           byte_cnt;
   logic [SW-1:0]           stall_cnt;
   logic                    last_q;
   logic [N_REQ-1:0][7:0]   bytes;
   int                      j;

   assign bytes    = req_byte;
   assign next_ptr = IW'((int'(owner) + 1) % N_REQ);

   // Scan from the far end so the candidate closest to rr_ptr is written last and wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      j          = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(rr_ptr) + k) % N_REQ;
         if (req_valid[j]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(j);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ARB;
         rr_ptr     <= '0;
         owner      <= '0;
         byte_cnt   <= '0;
         stall_cnt  <= '0;
         last_q     <= 1'b0;
         req_ack    <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         forced_rel <= 1'b0;
         tx_send    <= 1'b0;
         tx_byte    <= 8'h00;
      end else begin
         tx_send    <= 1'b0;
         req_ack    <= '0;
         forced_rel <= 1'b0;
         case (state)
            ARB: begin
               if (pick_found) begin
                  owner     <= pick_idx;
                  grant     <= N_REQ'(1) << pick_idx;
                  busy      <= 1'b1;
                  byte_cnt  <= '0;
                  stall_cnt <= '0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (req_valid[owner]) begin
                  if (tx_ready) begin
                     tx_send   <= 1'b1;
                     tx_byte   <= bytes[owner];
                     req_ack   <= N_REQ'(1) << owner;
                     last_q    <= req_last[owner];
                     byte_cnt  <= byte_cnt + 1'b1;
                     stall_cnt <= '0;
                     state     <= WAIT_LO;
                  end
               end else if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
                  grant      <= '0;
                  busy       <= 1'b0;
                  rr_ptr     <= next_ptr;
                  forced_rel <= 1'b1;
                  state      <= ARB;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
            WAIT_LO: begin
               if (!tx_ready) state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (tx_ready) begin
                  if (last_q || byte_cnt == CW'(MAX_MSG)) begin
                     grant      <= '0;
                     busy       <= 1'b0;
                     rr_ptr     <= next_ptr;
                     forced_rel <= !last_q;
                     state      <= ARB;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester queues and a TX model drive the DUT,
// expected (owner, byte) pairs are queued with the stimulus and popped on every tx_send.
module tb_uart_tx_scheduler;

   localparam int N       = 4;
   localparam int MAXM    = 4;
   localparam int STALL   = 20;
   localparam int TX_BUSY = 10;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [N-1:0]     req_valid;
   logic [8*N-1:0]   req_byte;
   logic [N-1:0]     req_last;
   logic [N-1:0]     req_ack;
   logic [N-1:0]     grant;
   logic             busy;
   logic             forced_rel;
   logic             tx_ready;
   logic             tx_send;
   logic [7:0]       tx_byte;

   logic [8:0]       rq [N][$];
   logic [10:0]      exp_q [$];
   int               errors = 0;
   int               checks = 0;
   int               cyc = 0;
   int               send_cnt = 0;
   int               forced_cnt = 0;
   int               last_lat = 0;
   int               send_cyc = 0;
   int               forced_cyc = 0;
   int               tx_cnt = 0;
   int               ack_cnt [N];
   int               rise_cyc [N];

   uart_tx_scheduler #(.N_REQ(N), .MAX_MSG(MAXM), .STALL_LIMIT(STALL)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_byte(req_byte), .req_last(req_last),
      .req_ack(req_ack), .grant(grant), .busy(busy), .forced_rel(forced_rel),
      .tx_ready(tx_ready), .tx_send(tx_send), .tx_byte(tx_byte)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Requesters: present queue heads, pop on req_ack.
   initial begin
      logic [8:0] h;
      req_valid = '0;
      req_byte  = '0;
      req_last  = '0;
      for (int i = 0; i < N; i++) begin
         ack_cnt[i]  = 0;
         rise_cyc[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
               ack_cnt[i]++;
               if (rq[i].size() > 0) void'(rq[i].pop_front());
            end
            if (rq[i].size() > 0) begin
               h = rq[i][0];
               if (!req_valid[i]) rise_cyc[i] = cyc;
               req_valid[i]        = 1'b1;
               req_byte[8*i +: 8]  = h[7:0];
               req_last[i]         = h[8];
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
            end
         end
      end
   end

   // TX FSM model: leaves idle for TX_BUSY cycles after each accepted strobe.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            tx_ready = 1'b1;
            tx_cnt   = 0;
         end else if (tx_send && tx_ready) begin
            tx_ready = 1'b0;
            tx_cnt   = TX_BUSY;
         end else if (!tx_ready) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_ready = 1'b1;
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      logic [10:0]  e;
      logic [N-1:0] eg;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1) begin
            if (tx_send) begin
               send_cnt++;
               send_cyc = cyc;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_send: grant=%b byte=%h, expected no send", grant, tx_byte);
               end else begin
                  e  = exp_q.pop_front();
                  eg = N'(1) << e[10:8];
                  last_lat = cyc - rise_cyc[int'(e[10:8])];
                  if (grant !== eg || tx_byte !== e[7:0] || req_ack !== eg || busy !== 1'b1) begin
                     errors++;
                     $display("FAIL send: grant=%b byte=%h ack=%b busy=%b, expected grant=%b byte=%h ack=%b busy=1",
                              grant, tx_byte, req_ack, busy, eg, e[7:0], eg);
                  end
               end
            end else begin
               checks++;
               if (req_ack !== '0) begin
                  errors++;
                  $display("FAIL stray_ack: ack=%b without tx_send, expected 0", req_ack);
               end
            end
            if (forced_rel) begin
               forced_cnt++;
               forced_cyc = cyc;
               checks++;
               if (grant !== '0 || busy !== 1'b0) begin
                  errors++;
                  $display("FAIL forced_release_state: grant=%b busy=%b, expected 0 0", grant, busy);
               end
            end
         end
      end
   end

   task automatic push_req(input int i, input logic [7:0] b, input logic last);
      rq[i].push_back({last, b});
   endtask

   task automatic expect_send(input int o, input logic [7:0] b);
      exp_q.push_back({3'(o), b});
   endtask

   task automatic wait_sends(input int n, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 500; t++) begin
         @(posedge clk); #1;
         if (send_cnt >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && busy === 1'b0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) rq[i].delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      bit ok;
      int s;
      repeat (2) @(negedge clk);
      checks++;
      if ({grant, busy, req_ack, tx_send, forced_rel, tx_byte} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: grant=%b busy=%b ack=%b send=%b forced=%b byte=%h, expected all 0",
                  grant, busy, req_ack, tx_send, forced_rel, tx_byte);
      end
      reset_n = 1'b1;
      push_req(0, 8'h55, 1'b0);
      push_req(0, 8'h56, 1'b1);
      expect_send(0, 8'h55);
      wait_sends(1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_first_send: timeout, expected a send"); end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (busy !== 1'b1 || tx_byte !== 8'h55) begin
         errors++;
         $display("FAIL reset_precondition: busy=%b byte=%h, expected 1 55", busy, tx_byte);
      end
      reset_n = 1'b0;
      rq[0].delete();
      exp_q.delete();
      #1;
      checks++;
      if ({grant, busy, req_ack, tx_send, forced_rel, tx_byte} !== '0) begin
         errors++;
         $display("FAIL async_reset: grant=%b busy=%b ack=%b send=%b forced=%b byte=%h, expected all 0",
                  grant, busy, req_ack, tx_send, forced_rel, tx_byte);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      s = send_cnt;
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (send_cnt !== s || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_abandon: sends=%0d busy=%b, expected sends=%0d busy=0", send_cnt, busy, s);
      end
   endtask

   task automatic test_solo();
      bit ok;
      int s, a0;
      s  = send_cnt;
      a0 = ack_cnt[0];
      push_req(0, 8'h48, 1'b0);
      push_req(0, 8'h49, 1'b0);
      push_req(0, 8'h0A, 1'b1);
      expect_send(0, 8'h48);
      expect_send(0, 8'h49);
      expect_send(0, 8'h0A);
      wait_sends(s + 1, ok);
      checks++;
      if (!ok || last_lat !== 2) begin
         errors++;
         $display("FAIL solo_latency: ok=%0d latency=%0d, expected ok=1 latency=2", ok, last_lat);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL solo_done: timeout, pending=%0d expected 0", exp_q.size()); end
      checks++;
      if (ack_cnt[0] - a0 !== 3 || grant !== '0) begin
         errors++;
         $display("FAIL solo_acks: acks=%0d grant=%b, expected 3 0000", ack_cnt[0] - a0, grant);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int f0;
      do_reset();
      f0 = forced_cnt;
      push_req(0, 8'hA0, 1'b1);
      push_req(0, 8'hA4, 1'b1);
      push_req(1, 8'hA1, 1'b1);
      push_req(1, 8'hA5, 1'b1);
      push_req(2, 8'hA2, 1'b1);
      push_req(3, 8'hA3, 1'b1);
      expect_send(0, 8'hA0);
      expect_send(1, 8'hA1);
      expect_send(2, 8'hA2);
      expect_send(3, 8'hA3);
      expect_send(0, 8'hA4);
      expect_send(1, 8'hA5);
      wait_idle(ok);
      checks++;
      if (!ok || forced_cnt !== f0) begin
         errors++;
         $display("FAIL rr_done: ok=%0d forced=%0d pending=%0d, expected ok=1 forced=%0d pending=0",
                  ok, forced_cnt, exp_q.size(), f0);
      end
   endtask

   task automatic test_atomicity();
      bit ok;
      int s, f0;
      s  = send_cnt;
      f0 = forced_cnt;
      for (int k = 0; k < 4; k++) begin
         push_req(1, 8'hB0 + 8'(k), k == 3);
         expect_send(1, 8'hB0 + 8'(k));
      end
      expect_send(0, 8'hC0);
      wait_sends(s + 1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL atomic_start: timeout, expected a send"); end
      push_req(0, 8'hC0, 1'b1);
      wait_idle(ok);
      checks++;
      if (!ok || forced_cnt !== f0) begin
         errors++;
         $display("FAIL atomic_done: ok=%0d forced=%0d, expected ok=1 forced=%0d", ok, forced_cnt, f0);
      end
   endtask

   task automatic test_max_msg();
      bit ok;
      int s, f0;
      s  = send_cnt;
      f0 = forced_cnt;
      for (int k = 0; k < 6; k++) push_req(2, 8'hD0 + 8'(k), k == 5);
      for (int k = 0; k < 4; k++) expect_send(2, 8'hD0 + 8'(k));
      expect_send(3, 8'hE0);
      expect_send(2, 8'hD4);
      expect_send(2, 8'hD5);
      wait_sends(s + 1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL max_start: timeout, expected a send"); end
      push_req(3, 8'hE0, 1'b1);
      wait_idle(ok);
      checks++;
      if (!ok || forced_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL max_release: ok=%0d forced_pulses=%0d, expected ok=1 forced_pulses=1", ok, forced_cnt - f0);
      end
   endtask

   task automatic test_stall();
      bit ok;
      int s, f0, fsend;
      s  = send_cnt;
      f0 = forced_cnt;
      push_req(3, 8'hF0, 1'b0);
      expect_send(3, 8'hF0);
      expect_send(1, 8'h61);
      wait_sends(s + 1, ok);
      fsend = send_cyc;
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_start: timeout, expected a send"); end
      push_req(1, 8'h61, 1'b1);
      wait_idle(ok);
      checks++;
      if (!ok || forced_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL stall_release: ok=%0d forced_pulses=%0d, expected ok=1 forced_pulses=1", ok, forced_cnt - f0);
      end
      checks++;
      if (forced_cyc - fsend !== TX_BUSY + 1 + STALL) begin
         errors++;
         $display("FAIL stall_timing: send-to-release=%0d cycles, expected %0d", forced_cyc - fsend, TX_BUSY + 1 + STALL);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      test_reset();
      test_solo();
      test_round_robin();
      test_atomicity();
      test_max_msg();
      test_stall();
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
